// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce_sync input conditioner.
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_t;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level; reusable for any CDC input.
module sync_chain #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronises and debounces an asynchronous level; emits registered level plus rise/fall pulses.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    input  logic tick_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int unsigned     CNT_W    = cnt_width(int'(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("debounce_sync: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic             w_sync_s;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_q;
    logic             w_q_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             r_busy;

    sync_chain #(
        .STAGES   (SYNC_STAGES),
        .RESET_VAL(RESET_VAL)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  (d_i),
        .q_o  (w_sync_s)
    );

    // Next-state: everything holds unless this edge is ticked.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (tick_i) begin
            case (r_state)
                STABLE: begin
                    w_cnt_nxt = '0;
                    if (w_sync_s != r_q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_q_nxt    = w_sync_s;
                            w_rise_nxt = w_sync_s;
                            w_fall_nxt = ~w_sync_s;
                        end else begin
                            w_state_nxt = COUNT;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                COUNT: begin
                    if (w_sync_s == r_q) begin
                        w_state_nxt = STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = STABLE;
                        w_cnt_nxt   = '0;
                        w_q_nxt     = w_sync_s;
                        w_rise_nxt  = w_sync_s;
                        w_fall_nxt  = ~w_sync_s;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STABLE;
            r_cnt   <= '0;
            r_q     <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= (w_state_nxt == COUNT);
        end
    end

    assign q_o    = r_q;
    assign rise_o = r_rise;
    assign fall_o = r_fall;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench: default debounce_sync and a SYNC_STAGES=3/DEBOUNCE_CYCLES=1 variant share stimulus.
module tb_debounce_sync;

    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic d = 1'b0;
    logic tick = 1'b1;
    logic q0, r0, f0, b0;
    logic q1, r1, f1, b1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    // Reference model state: synchroniser history and ticked-sample history per DUT.
    logic [7:0]  m_pipe[2];
    logic [31:0] m_hist[2];
    int          m_hc[2];
    logic        m_q[2];
    logic        m_busy[2];

    debounce_sync dut0 (
        .clk(clk), .reset(reset), .d_i(d), .tick_i(tick),
        .q_o(q0), .rise_o(r0), .fall_o(f0), .busy_o(b0)
    );

    debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .d_i(d), .tick_i(tick),
        .q_o(q1), .rise_o(r1), .fall_o(f1), .busy_o(b1)
    );

    always #5 clk = ~clk;

    // q flips once the last DC ticked synchronised samples all disagree with q.
    function automatic exp_t model_step(input int idx, input logic rn, input logic dv, input logic tv);
        exp_t        e;
        int          s_stages;
        int          dc;
        logic        s_old;
        logic [31:0] mask;
        s_stages = (idx == 0) ? 2 : 3;
        dc       = (idx == 0) ? 4 : 1;
        e        = '0;
        if (!rn) begin
            m_pipe[idx] = '0;
            m_hist[idx] = '0;
            m_hc[idx]   = 0;
            m_q[idx]    = 1'b0;
            m_busy[idx] = 1'b0;
            return e;
        end
        s_old       = m_pipe[idx][s_stages-1];
        m_pipe[idx] = {m_pipe[idx][6:0], dv};
        if (tv) begin
            m_hist[idx] = {m_hist[idx][30:0], s_old};
            if (m_hc[idx] < 32) m_hc[idx] = m_hc[idx] + 1;
            mask = (32'd1 << dc) - 32'd1;
            if (m_hc[idx] >= dc && (m_hist[idx] & mask) == (m_q[idx] ? 32'd0 : mask)) begin
                m_q[idx]    = ~m_q[idx];
                e.rise      = m_q[idx];
                e.fall      = ~m_q[idx];
                m_busy[idx] = 1'b0;
            end else begin
                m_busy[idx] = (s_old != m_q[idx]);
            end
        end
        e.q    = m_q[idx];
        e.busy = m_busy[idx];
        return e;
    endfunction

    task automatic drive(input logic rn, input logic dv, input logic tv);
        @(negedge clk);
        reset = rn;
        d     = dv;
        tick  = tv;
        sb0.push_back(model_step(0, rn, dv, tv));
        sb1.push_back(model_step(1, rn, dv, tv));
    endtask

    // Monitor: every clock each DUT presents a registered result; pop and compare.
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb0.size() != 0) begin
                e = sb0.pop_front();
                g = '{q: q0, rise: r0, fall: f0, busy: b0};
                compared++;
                if (g !== e) begin
                    mismatched++;
                    $display("FAIL dut0 cycle %0d {q,rise,fall,busy}: got %b expected %b", cyc, g, e);
                end
            end
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                g = '{q: q1, rise: r1, fall: f1, busy: b1};
                compared++;
                if (g !== e) begin
                    mismatched++;
                    $display("FAIL dut1 cycle %0d {q,rise,fall,busy}: got %b expected %b", cyc, g, e);
                end
            end
        end
    end

    initial begin
        int   lat0;
        int   lat1;
        int   run;
        logic dv;
        logic rn;

        // Reset held with d=1, then release and let the level propagate.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1);

        // Clean-rise latency measured directly on both DUTs.
        lat0 = 0;
        lat1 = 0;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, 1'b1, 1'b1);
            @(posedge clk);
            #2;
            if (lat0 == 0 && q0 === 1'b1) lat0 = k;
            if (lat1 == 0 && q1 === 1'b1) lat1 = k;
        end
        compared++;
        if (lat0 != 6) begin
            mismatched++;
            $display("FAIL latency_dut0: got %0d edges expected 6", lat0);
        end
        compared++;
        if (lat1 != 4) begin
            mismatched++;
            $display("FAIL latency_dut1: got %0d edges expected 4", lat1);
        end

        // Glitches of 3 and 4 clocks against a low baseline.
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)  drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)  drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1);

        // Tick gating: one ticked edge in four, d high then held low.
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b1, (i % 4) == 3);
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, (i % 4) == 3);

        // Reset asserted while the default DUT is at cnt=2.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        #1;
        compared++;
        if ({q0, r0, f0, b0, q1, r1, f1, b1} !== 8'b0) begin
            mismatched++;
            $display("FAIL async_reset_clear: got %b expected 00000000", {q0, r0, f0, b0, q1, r1, f1, b1});
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1);

        // Randomised bursts of varying length, mostly-ticked, with rare resets.
        run = 0;
        dv  = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (run == 0) begin
                dv  = ~dv;
                run = $urandom_range(1, 8);
            end
            run--;
            rn = ($urandom_range(0, 199) != 0);
            drive(rn, dv, $urandom_range(0, 3) != 0);
        end

        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", sb0.size(), sb1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
